btn_pulse_gen: RTL and testbench

Converts the debounced button levels from the anti-jitter stage into single-cycle event pulses in the system clock domain: press, release, and optional auto-repeat while held. It sits directly downstream of the debouncers and feeds the CPU step/run control and display-select logic. The debouncer output is registered on a derived 1 ms clock, so this block also owns the synchronisation into `clk`.

---
 rtl/btn_pulse_pkg.sv | 19 +
 rtl/btn_pulse_chan.sv | 132 +++++++++++++
 rtl/btn_pulse_gen.sv | 70 +++++++
 tb/tb_btn_pulse_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_pkg.sv
// Shared types and default timing constants for the button pulse generator.
package btn_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_t;

    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_HOLD_MS   = 500;
    localparam int DEF_REPEAT_MS = 100;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_pulse_chan.sv
// One button channel: two-flop synchroniser, edge register and, when
// BTN_PULSE_AUTO_REPEAT_EN is defined, the hold/auto-repeat FSM.
module btn_pulse_chan
    import btn_pulse_pkg::*;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
#(
    parameter int HOLD_MS   = DEF_HOLD_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
`ifdef BTN_PULSE_AUTO_REPEAT_EN
    input  logic tick,
    output logic repeat_pulse,
`endif
    output logic held,
    output logic press_pulse,
    output logic release_pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic press_q, press_d;
    logic release_q, release_d;

    always_comb begin
        s1_d      = btn_db;
        s2_d      = s1_q;
        prev_d    = s2_q;
        press_d   = s2_q & ~prev_q;
        release_d = ~s2_q & prev_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real registers do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign held          = s2_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_PULSE_AUTO_REPEAT_EN
    localparam int CNT_W = cnt_width((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             repeat_q, repeat_d;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        repeat_d = 1'b0;

        // A released button overrides everything, including a terminal tick.
        if (!s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!prev_q) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (tick) begin
                        if (cnt_q == HOLD_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (tick) begin
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`endif

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounced button levels to single-cycle press/release pulses; auto-repeat
// pulses and the shared 1 ms tick exist only with BTN_PULSE_AUTO_REPEAT_EN.
module btn_pulse_gen
    import btn_pulse_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int HOLD_MS   = DEF_HOLD_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_db,
`ifdef BTN_PULSE_AUTO_REPEAT_EN
    output logic [N_BTN-1:0] repeat_pulse,
`endif
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    if (N_BTN < 1 || TICK_DIV < 1 || HOLD_MS < 1 || REPEAT_MS < 1) begin : g_bad_param
        $error("btn_pulse_gen: all parameters must be at least 1");
    end

`ifdef BTN_PULSE_AUTO_REPEAT_EN
    localparam int TICK_W = cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    // Free-running, so the phase of the first repeat relative to a press varies.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_pulse_chan
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        #(
            .HOLD_MS   (HOLD_MS),
            .REPEAT_MS (REPEAT_MS)
        )
`endif
        u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_db        (btn_db[i]),
`ifdef BTN_PULSE_AUTO_REPEAT_EN
            .tick          (tick),
            .repeat_pulse  (repeat_pulse[i]),
`endif
            .held          (held[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed vector table, corner-case
// sequences and randomized stimulus against a history-based reference model.
module tb_btn_pulse_gen;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int HM = 3;
    localparam int RM = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_db;
    logic [N-1:0] held, press_pulse, release_pulse;
    logic [N-1:0] rep_obs;

    always #5 clk = ~clk;

    btn_pulse_gen #(
        .N_BTN     (N),
        .TICK_DIV  (TD),
        .HOLD_MS   (HM),
        .REPEAT_MS (RM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_db        (btn_db),
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        .repeat_pulse  (rep_obs),
`endif
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

`ifndef BTN_PULSE_AUTO_REPEAT_EN
    assign rep_obs = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs after edge e follow from the inputs sampled at
    // edges e-1..e-3; repeats from the number of ticks seen since the press.
    int           edge_n;
    logic [N-1:0] hist [4];
    logic [N-1:0] e_held, e_press, e_rel, e_rep;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
    bit           active [N];
    int           ticks  [N];
`endif

    task automatic model_reset();
        edge_n = 0;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        e_held = '0; e_press = '0; e_rel = '0; e_rep = '0;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0;
            ticks[i]  = 0;
        end
`endif
    endtask

    task automatic model_step(input logic [N-1:0] in_now);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = in_now;
        edge_n++;
        e_held  = hist[1];
        e_press = hist[2] & ~hist[3];
        e_rel   = ~hist[2] & hist[3];
        e_rep   = '0;
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        for (int i = 0; i < N; i++) begin
            if (!hist[2][i]) begin
                active[i] = 1'b0;
            end else if (active[i] && (edge_n % TD == 0)) begin
                ticks[i]++;
                if (ticks[i] == HM || (ticks[i] > HM && (ticks[i] - HM) % RM == 0))
                    e_rep[i] = 1'b1;
            end
            if (e_press[i]) begin
                active[i] = 1'b1;
                ticks[i]  = 0;
            end
        end
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step(btn_db);
        @(negedge clk);
        if (rst_n) begin
            check("held",    held,          e_held);
            check("press",   press_pulse,   e_press);
            check("release", release_pulse, e_rel);
            check("repeat",  rep_obs,       e_rep);
        end else begin
            check("rst_outputs", {held, press_pulse, release_pulse, rep_obs}, '0);
        end
    endtask

    task automatic mid_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("rst_async", {held, press_pulse, release_pulse, rep_obs}, '0);
        model_reset();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic [N-1:0] held;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } vec_t;

    vec_t tbl [20];
    int   p_cyc, r_cyc, n_press, n_rel, first_rep;
    int   rep_q [$];

    initial begin
        // Rows 0-9: short press on channel 0; rows 10-19: all four pressed
        // together, then released one channel per cycle.
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1110, 4'b1111, 4'b1111, 4'b0000};
        tbl[13] = '{4'b1100, 4'b1110, 4'b0000, 4'b0000};
        tbl[14] = '{4'b1000, 4'b1100, 4'b0000, 4'b0001};
        tbl[15] = '{4'b0000, 4'b1000, 4'b0000, 4'b0010};
        tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

        rst_n  = 1'b0;
        btn_db = '0;
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            btn_db = tbl[i].btn;
            cycle();
            check("tbl_held",    held,          tbl[i].held);
            check("tbl_press",   press_pulse,   tbl[i].press);
            check("tbl_release", release_pulse, tbl[i].rel);
            check("tbl_repeat",  rep_obs,       '0);
        end

        // Long hold on channel 1.
        btn_db = '0;
        mid_reset(2);
        btn_db = 4'b0010;
        p_cyc = -1; r_cyc = -1;
        rep_q.delete();
        for (int c = 1; c <= 55; c++) begin
            if (c == 41) btn_db = '0;
            cycle();
            if (press_pulse[1])   p_cyc = c;
            if (release_pulse[1]) r_cyc = c;
            if (rep_obs[1])       rep_q.push_back(c);
        end
        check("hold_press_cyc",   p_cyc, 3);
        check("hold_release_cyc", r_cyc, 43);
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        check("hold_rep_count", rep_q.size(), 4);
        if (rep_q.size() > 0) begin
            check("hold_first_gap_9_12",
                  ((rep_q[0] - p_cyc) >= 9) && ((rep_q[0] - p_cyc) <= 12), 1);
            check("hold_rep_before_release", rep_q[rep_q.size()-1] < r_cyc, 1);
        end
        for (int k = 1; k < rep_q.size(); k++)
            check("hold_rep_spacing", rep_q[k] - rep_q[k-1], 8);
`else
        check("hold_rep_count", rep_q.size(), 0);
`endif

        // Channel 2 released so that s2 falls during the terminal tick.
        btn_db = '0;
        mid_reset(2);
        btn_db = 4'b0100;
        n_rel = 0; r_cyc = -1;
        rep_q.delete();
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) btn_db = '0;
            cycle();
            if (release_pulse[2]) begin n_rel++; r_cyc = c; end
            if (rep_obs[2]) rep_q.push_back(c);
        end
        check("term_tick_rep_count", rep_q.size(), 0);
        check("term_tick_rel_count", n_rel, 1);
        check("term_tick_rel_cyc",   r_cyc, 12);

        // Reset while channel 0 is held in auto-repeat, cutting a repeat pulse.
        btn_db = '0;
        mid_reset(2);
        btn_db = 4'b0001;
        repeat (20) cycle();
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        check("rst_hold_rep_live", rep_obs[0], 1);
`endif
        mid_reset(3);
        n_press = 0; p_cyc = -1; first_rep = -1;
        for (int c = 1; c <= 24; c++) begin
            cycle();
            if (press_pulse[0]) begin n_press++; p_cyc = c; end
            if (rep_obs[0] && first_rep < 0) first_rep = c;
        end
        check("rst_hold_press_count", n_press, 1);
        check("rst_hold_press_cyc",   p_cyc, 3);
`ifdef BTN_PULSE_AUTO_REPEAT_EN
        check("rst_hold_first_rep", first_rep, 12);
`endif

        // Randomized levels with occasional asynchronous resets.
        btn_db = '0;
        mid_reset(2);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) btn_db[i] = ~btn_db[i];
            if ($urandom_range(299) == 0) mid_reset(2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
